// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit (shift-add / restoring divide).
module ex_stage_md #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_e,
    input  logic            regwrite_e,
    input  logic            memwrite_e,
    input  logic            jump_e,
    input  logic            branch_e,
    input  logic            alu_src_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_control_e,
    input  logic [2:0]      branch_control_e,
    input  logic            md_valid_e,
    input  logic [2:0]      md_op_e,
    input  logic [XLEN-1:0] rs1_data_e,
    input  logic [XLEN-1:0] rs2_data_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus_4_e,
    input  logic [XLEN-1:0] immediate_e,
    input  logic [4:0]      rd_e,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] result_w,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    output logic            stall_e,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] writedata,
    output logic [XLEN-1:0] ex_mem_pc_plus_4_e,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_regwrite_e,
    output logic [1:0]      ex_mem_result_src_e,
    output logic            ex_mem_memwrite_e
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10;

    logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_out;
    logic [SHW-1:0]  shamt;
    logic            br_taken;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    always_comb begin
        case (forward_a_e)
            2'b00:   fwd_a = rs1_data_e;
            2'b01:   fwd_a = result_w;
            2'b10:   fwd_a = alu_result_m;
            default: fwd_a = '0;
        endcase
        case (forward_b_e)
            2'b00:   fwd_b = rs2_data_e;
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = alu_result_m;
            default: fwd_b = '0;
        endcase
    end

    assign src_b = alu_src_e ? immediate_e : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_control_e)
            ALU_ADD:  alu_out = fwd_a + src_b;
            ALU_SUB:  alu_out = fwd_a - src_b;
            ALU_AND:  alu_out = fwd_a & src_b;
            ALU_OR:   alu_out = fwd_a | src_b;
            ALU_XOR:  alu_out = fwd_a ^ src_b;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            ALU_SLL:  alu_out = fwd_a << shamt;
            ALU_SRL:  alu_out = fwd_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(fwd_a) >>> shamt);
            ALU_LUI:  alu_out = src_b;
            default:  alu_out = '0;
        endcase
    end

    // Branches always compare the two register operands, never the immediate.
    always_comb begin
        case (branch_control_e)
            3'b000:  br_taken = (fwd_a == fwd_b);
            3'b001:  br_taken = (fwd_a != fwd_b);
            3'b100:  br_taken = $signed(fwd_a) <  $signed(fwd_b);
            3'b101:  br_taken = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  br_taken = fwd_a <  fwd_b;
            3'b111:  br_taken = fwd_a >= fwd_b;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_src_e    = ((branch_e & br_taken) | jump_e) & ~md_valid_e;
    assign pc_target_e = pc_e + immediate_e;

`ifdef EX_MULDIV_EN
    localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
                           MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    md_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, opb_q, opa_q;
    logic [2:0]      op_q;
    logic            neg_q, bzero_q;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    assign a_sgn = (md_op_e != MD_MULHU) & (md_op_e != MD_DIVU) & (md_op_e != MD_REMU);
    assign b_sgn = a_sgn & (md_op_e != MD_MULHSU);
    assign a_neg = a_sgn & fwd_a[XLEN-1];
    assign b_neg = b_sgn & fwd_b[XLEN-1];
    assign a_mag = a_neg ? -fwd_a : fwd_a;
    assign b_mag = b_neg ? -fwd_b : fwd_b;

    // hi:lo is the product accumulator (multiply) or remainder:quotient (divide).
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    assign div_diff = div_sh[XLEN-1:0] - opb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            opa_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
        end else if (flush_e) begin
            state_q <= MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: if (md_valid_e) begin
                    state_q <= MD_BUSY;
                    cnt_q   <= CNT_W'(XLEN);
                    hi_q    <= '0;
                    lo_q    <= a_mag;
                    opb_q   <= b_mag;
                    opa_q   <= fwd_a;
                    op_q    <= md_op_e;
                    neg_q   <= (md_op_e[2] & md_op_e[1]) ? a_neg : (a_neg ^ b_neg);
                    bzero_q <= (fwd_b == '0);
                end
                MD_BUSY: begin
                    if (op_q[2]) begin
                        hi_q <= div_ge ? div_diff : div_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= MD_DONE;
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -lo_q : lo_q;
    assign rem_s  = neg_q ? -hi_q : hi_q;

    always_comb begin
        case (op_q)
            MD_MUL:                      md_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             md_res = bzero_q ? '1 : quo_s;
            default:                     md_res = bzero_q ? opa_q : rem_s;
        endcase
    end

    assign md_done = (state_q == MD_DONE);
    assign stall_e = ((state_q == MD_IDLE) & md_valid_e) | (state_q == MD_BUSY);
`else
    logic [2:0]       unused_md_op;
    logic [CNT_W-1:0] unused_cnt;
    assign unused_md_op = md_op_e;
    assign unused_cnt   = '0;
    assign md_done      = 1'b0;
    assign md_res       = '0;
    assign stall_e      = 1'b0;
`endif

    logic [XLEN-1:0] alu_q, wd_q, pc4_q;
    logic [4:0]      rd_q;
    logic            regwrite_q, memwrite_q;
    logic [1:0]      rsrc_q;
    logic [XLEN-1:0] alu_d;

    // A muldiv op outside DONE never reaches here unstalled, so it only lands as 0 when the unit is absent.
    assign alu_d = md_done ? md_res : (md_valid_e ? '0 : alu_out);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_q <= '0; wd_q <= '0; pc4_q <= '0; rd_q <= '0;
            regwrite_q <= 1'b0; memwrite_q <= 1'b0; rsrc_q <= '0;
        end else if (flush_e || stall_e) begin
            alu_q <= '0; wd_q <= '0; pc4_q <= '0; rd_q <= '0;
            regwrite_q <= 1'b0; memwrite_q <= 1'b0; rsrc_q <= '0;
        end else begin
            alu_q      <= alu_d;
            wd_q       <= fwd_b;
            pc4_q      <= pc_plus_4_e;
            rd_q       <= rd_e;
            regwrite_q <= regwrite_e;
            memwrite_q <= memwrite_e;
            rsrc_q     <= result_src_e;
        end
    end

    assign alu_result          = alu_q;
    assign writedata           = wd_q;
    assign ex_mem_pc_plus_4_e  = pc4_q;
    assign ex_mem_rd           = rd_q;
    assign ex_mem_regwrite_e   = regwrite_q;
    assign ex_mem_memwrite_e   = memwrite_q;
    assign ex_mem_result_src_e = rsrc_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized bench for ex_stage_md against an arithmetic reference model.
module tb_ex_stage_md;
    localparam int XLEN = 32;

    logic            clk = 1'b0, reset_n = 1'b0, flush_e = 1'b0;
    logic            regwrite_e = 0, memwrite_e = 0, jump_e = 0, branch_e = 0, alu_src_e = 0;
    logic [1:0]      result_src_e = '0;
    logic [3:0]      alu_control_e = '0;
    logic [2:0]      branch_control_e = '0;
    logic            md_valid_e = 1'b0;
    logic [2:0]      md_op_e = '0;
    logic [XLEN-1:0] rs1_data_e = '0, rs2_data_e = '0, pc_e = '0, pc_plus_4_e = '0, immediate_e = '0;
    logic [4:0]      rd_e = '0;
    logic [XLEN-1:0] alu_result_m = '0, result_w = '0;
    logic [1:0]      forward_a_e = '0, forward_b_e = '0;
    logic            stall_e, pc_src_e;
    logic [XLEN-1:0] pc_target_e, alu_result, writedata, ex_mem_pc_plus_4_e;
    logic [4:0]      ex_mem_rd;
    logic            ex_mem_regwrite_e, ex_mem_memwrite_e;
    logic [1:0]      ex_mem_result_src_e;

    ex_stage_md #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .flush_e(flush_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
        .alu_src_e(alu_src_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .branch_control_e(branch_control_e), .md_valid_e(md_valid_e), .md_op_e(md_op_e),
        .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e), .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e),
        .immediate_e(immediate_e), .rd_e(rd_e), .alu_result_m(alu_result_m), .result_w(result_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_e(stall_e), .pc_src_e(pc_src_e),
        .pc_target_e(pc_target_e), .alu_result(alu_result), .writedata(writedata),
        .ex_mem_pc_plus_4_e(ex_mem_pc_plus_4_e), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite_e(ex_mem_regwrite_e), .ex_mem_result_src_e(ex_mem_result_src_e),
        .ex_mem_memwrite_e(ex_mem_memwrite_e)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'b00:   return rf;
            2'b01:   return result_w;
            2'b10:   return alu_result_m;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            4'd10:   return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : $unsigned($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Checks the current (non-muldiv) EX inputs: combinational outputs now, EX/MEM after one edge.
    task automatic check_alu(input string tag);
        logic [31:0] a, rb, b, e_alu, e_tgt, e_pc4;
        logic e_src, e_rw, e_mw;
        logic [4:0] e_rd;
        logic [1:0] e_rs;
        a = fwd_ref(forward_a_e, rs1_data_e);
        rb = fwd_ref(forward_b_e, rs2_data_e);
        b = alu_src_e ? immediate_e : rb;
        e_alu = alu_ref(alu_control_e, a, b);
        e_src = (branch_e && br_ref(branch_control_e, a, rb)) || jump_e;
        e_tgt = pc_e + immediate_e;
        e_pc4 = pc_plus_4_e; e_rd = rd_e; e_rw = regwrite_e; e_mw = memwrite_e; e_rs = result_src_e;
        #1;
        chk({tag, ".pc_src"}, pc_src_e, e_src);
        chk({tag, ".target"}, pc_target_e, e_tgt);
        chk({tag, ".stall"}, stall_e, 0);
        @(posedge clk); #1;
        chk({tag, ".alu"}, alu_result, e_alu);
        chk({tag, ".wdata"}, writedata, rb);
        chk({tag, ".pc4"}, ex_mem_pc_plus_4_e, e_pc4);
        chk({tag, ".rd"}, ex_mem_rd, e_rd);
        chk({tag, ".rw"}, ex_mem_regwrite_e, e_rw);
        chk({tag, ".mw"}, ex_mem_memwrite_e, e_mw);
        chk({tag, ".rsrc"}, ex_mem_result_src_e, e_rs);
    endtask

    task automatic rand_alu_inputs();
        md_valid_e = 0; flush_e = 0;
        alu_control_e = 4'($urandom_range(0, 11));
        branch_control_e = 3'($urandom); branch_e = 1'($urandom); jump_e = ($urandom_range(0, 7) == 0);
        alu_src_e = 1'($urandom); regwrite_e = 1'($urandom); memwrite_e = 1'($urandom);
        result_src_e = 2'($urandom); rd_e = 5'($urandom);
        forward_a_e = 2'($urandom); forward_b_e = 2'($urandom);
        rs1_data_e = $urandom; rs2_data_e = ($urandom_range(0, 3) == 0) ? rs1_data_e : $urandom;
        alu_result_m = $urandom; result_w = $urandom;
        pc_e = $urandom; pc_plus_4_e = pc_e + 4; immediate_e = $urandom;
    endtask

    // Presents one muldiv op right after an edge; returns right after the edge that writes it back.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] want;
        int stalls;
        bit rw_seen;
        want = md_ref(op, a, b);
        md_valid_e = 1; md_op_e = op; rs1_data_e = a; rs2_data_e = b;
        forward_a_e = 0; forward_b_e = 0; regwrite_e = 1; memwrite_e = 0; result_src_e = 0;
        jump_e = 1; branch_e = 0; alu_src_e = 0; flush_e = 0; rd_e = 5'($urandom);
        #1;
        chk("md.pc_src_forced", pc_src_e, 0);
`ifdef EX_MULDIV_EN
        stalls = 0; rw_seen = 0;
        while (stall_e && stalls < 200) begin
            stalls++;
            @(posedge clk); #1;
            rs1_data_e = $urandom; rs2_data_e = $urandom; alu_result_m = $urandom; result_w = $urandom;
            if (ex_mem_regwrite_e) rw_seen = 1;
        end
        chk("md.stall_cycles", stalls, XLEN + 1);
        chk("md.bubble_rw", rw_seen, 0);
        @(posedge clk); #1;
        $display("md op=%0d a=%h b=%h -> %h", op, a, b, alu_result);
        chk("md.result", alu_result, want);
        chk("md.rw", ex_mem_regwrite_e, 1);
`else
        chk("md.nostall", stall_e, 0);
        @(posedge clk); #1;
        chk("md.zero_result", alu_result, 0);
        chk("md.rw", ex_mem_regwrite_e, 1);
`endif
        md_valid_e = 0; jump_e = 0;
    endtask

    initial begin
        #12;
        chk("rst.alu", alu_result, 0);
        chk("rst.rw", ex_mem_regwrite_e, 0);
        chk("rst.stall", stall_e, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // forwarding: A from MEM, B from WB
        alu_control_e = 4'd0; alu_src_e = 0; regwrite_e = 1; rd_e = 5'd3;
        forward_a_e = 2'b10; alu_result_m = 32'h10; forward_b_e = 2'b01; result_w = 32'h5;
        rs1_data_e = 32'hDEAD; rs2_data_e = 32'hBEEF; pc_e = 32'h40; pc_plus_4_e = 32'h44;
        check_alu("fwd");
        chk("fwd.const_alu", alu_result, 32'h15);
        chk("fwd.const_wd", writedata, 32'h5);

        // BEQ taken
        forward_a_e = 0; forward_b_e = 0; rs1_data_e = 32'd9; rs2_data_e = 32'd9;
        branch_e = 1; branch_control_e = 3'b000; pc_e = 32'h100; immediate_e = 32'h20; regwrite_e = 0;
        #1;
        chk("beq.pc_src", pc_src_e, 1);
        chk("beq.target", pc_target_e, 32'h120);
        check_alu("beq");

        // flush squashes a normal op
        flush_e = 1; regwrite_e = 1; memwrite_e = 1; alu_control_e = 4'd0; rs1_data_e = 32'd1;
        @(posedge clk); #1;
        chk("flush.rw", ex_mem_regwrite_e, 0);
        chk("flush.alu", alu_result, 0);
        flush_e = 0;

        for (int i = 0; i < 40; i++) begin
            rand_alu_inputs();
            check_alu("rand_alu");
        end

        // directed muldiv, issued back to back
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_md(3'd3, 32'hFFFF_FFFF, 32'd2);
        run_md(3'd4, 32'd7, 32'd0);
        run_md(3'd6, 32'd7, 32'd0);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'd2, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_md(3'd7, 32'hFFFF_FFF9, 32'd0);
        for (int i = 0; i < 12; i++) begin
            run_md(3'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom);
        end

`ifdef EX_MULDIV_EN
        // flush in the 10th BUSY cycle
        md_valid_e = 1; md_op_e = 3'd0; rs1_data_e = 32'd123; rs2_data_e = 32'd456; regwrite_e = 1;
        forward_a_e = 0; forward_b_e = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        chk("flushmd.busy", stall_e, 1);
        flush_e = 1; md_valid_e = 0;
        @(posedge clk); #1;
        flush_e = 0;
        chk("flushmd.stall", stall_e, 0);
        chk("flushmd.rw", ex_mem_regwrite_e, 0);
        chk("flushmd.alu", alu_result, 0);
        @(posedge clk); #1;
        chk("flushmd.idle", stall_e, 0);
        run_md(3'd5, 32'd100, 32'd7);

        // reset mid-op: unit restarts from IDLE
        md_valid_e = 1; md_op_e = 3'd4; rs1_data_e = 32'd1000; rs2_data_e = 32'd3;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #2; reset_n = 0; md_valid_e = 0;
        #1;
        chk("rstmd.stall", stall_e, 0);
        chk("rstmd.alu", alu_result, 0);
        reset_n = 1;
        @(posedge clk); #1;
        chk("rstmd.idle", stall_e, 0);
        run_md(3'd4, 32'd1000, 32'd3);
`endif

        // async reset clears a populated EX/MEM register without an edge
        md_valid_e = 0; alu_control_e = 4'd0; alu_src_e = 0; forward_a_e = 0; forward_b_e = 0;
        rs1_data_e = 32'd3; rs2_data_e = 32'd4; regwrite_e = 1; memwrite_e = 1; result_src_e = 2'd2;
        rd_e = 5'd7; pc_plus_4_e = 32'h44;
        @(posedge clk); #1;
        chk("arst.pre_alu", alu_result, 32'd7);
        #2; reset_n = 0;
        #1;
        chk("arst.alu", alu_result, 0);
        chk("arst.wd", writedata, 0);
        chk("arst.pc4", ex_mem_pc_plus_4_e, 0);
        chk("arst.rd", ex_mem_rd, 0);
        chk("arst.rw", ex_mem_regwrite_e, 0);
        chk("arst.mw", ex_mem_memwrite_e, 0);
        chk("arst.rsrc", ex_mem_result_src_e, 0);
        reset_n = 1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with an iterative RV32M/RV64M multiply/divide unit. Sits between the ID/EX and EX/MEM pipeline registers. It performs operand forwarding, ALU and branch evaluation, and branch/jump target generation, and it owns the EX/MEM register. Multiply/divide ops run for multiple cycles; during that time the stage drives `stall_e` and injects bubbles into MEM.

## Interface
- `XLEN`, default 32: datapath width; must be 32 or 64.
- `CNT_W`, default `$clog2(XLEN)+1`: width of the iteration counter.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush_e` in 1: synchronous flush of the EX/MEM register and the muldiv FSM.
- `regwrite_e`, `memwrite_e`, `jump_e`, `branch_e`, `alu_src_e` in 1 each: decoded controls.
- `result_src_e` in 2: result select, passed to MEM.
- `alu_control_e` in 4: ALU op.
- `branch_control_e` in 3: branch compare type (funct3).
- `md_valid_e` in 1: the current EX instruction is an M-extension op.
- `md_op_e` in 3: M op, funct3 encoding (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- `rs1_data_e`, `rs2_data_e`, `pc_e`, `pc_plus_4_e`, `immediate_e` in XLEN: operands.
- `rd_e` in 5: destination register.
- `alu_result_m`, `result_w` in XLEN: forwarding sources.
- `forward_a_e`, `forward_b_e` in 2: forwarding select. 00 selects the register file, 01 selects `result_w`, 10 selects `alu_result_m`, 11 selects 0.
- `stall_e` out 1: hold the F/D/E registers.
- `pc_src_e` out 1: redirect fetch.
- `pc_target_e` out XLEN: `pc_e + immediate_e`, modulo 2^XLEN.
- `alu_result`, `writedata`, `ex_mem_pc_plus_4_e` out XLEN: EX/MEM registers.
- `ex_mem_rd` out 5, `ex_mem_regwrite_e` out 1, `ex_mem_result_src_e` out 2, `ex_mem_memwrite_e` out 1: EX/MEM registers.

## Operation
- Operand A is the forwarded rs1 value.
- Operand B is `immediate_e` if `alu_src_e` is set, otherwise the forwarded rs2 value.
- `writedata` always takes the forwarded rs2 value.
- `pc_src_e = (branch_e & branch_taken) | jump_e`. It is forced to 0 whenever `md_valid_e` is set.
- The muldiv FSM has three states: IDLE, BUSY, DONE.
  - IDLE and `md_valid_e`: latch the forwarded operands and `md_op_e`, load the counter with XLEN, go to BUSY. Forwarding sources are never re-read after this cycle.
  - BUSY: one shift-add step (multiply) or restoring-divide step (divide) per cycle, then decrement the counter. At counter == 1, go to DONE.
  - DONE: the result is valid; go to IDLE unconditionally. `md_valid_e` is still high in this cycle but must not restart the unit.
- `stall_e = (IDLE & md_valid_e) | BUSY`.
- Signed ops work on magnitudes and fix the sign at DONE.
- MULH, MULHSU and MULHU return the upper XLEN bits of the 2·XLEN product; MUL returns the lower XLEN bits.
- Divide by zero: quotient is all ones; remainder is the dividend.
- Signed overflow (MIN / −1): quotient is MIN; remainder is 0.
- EX/MEM update on each edge, in priority order: `reset_n` low, then `flush_e`, then stall, then normal.
  - Reset or flush: all EX/MEM outputs are 0 (bubble).
  - `stall_e` high: bubble, with `regwrite` and `memwrite` 0.
  - Normal: capture the stage outputs. In DONE, `alu_result` captures the muldiv result.
- `flush_e` during BUSY or DONE aborts the unit to IDLE. No result is written.

## Timing
- Reset (`reset_n` low, asynchronous): FSM goes to IDLE; every registered output is 0; `stall_e` and `pc_src_e` depend only on the inputs.
- ALU and branch ops: 1 cycle; the result appears in EX/MEM after the next edge.
- Muldiv op presented in cycle T:
  - `stall_e` is high in cycles T through T+XLEN.
  - DONE is cycle T+XLEN+1.
  - The result is in `alu_result` after the edge that ends cycle T+XLEN+1.
  - `ex_mem_regwrite_e` is 0 for the XLEN+1 cycles before that.
- Back-to-back muldiv ops: the second op enters IDLE one cycle after DONE, with no extra bubble.
- `reset_n` deasserting mid-op: the unit restarts from IDLE. No partial result is ever visible.

## Configuration
- `EX_MULDIV_EN` defined: the muldiv datapath, counter and FSM are built as above.
- `EX_MULDIV_EN` undefined: the muldiv logic is removed and `stall_e` is tied to 0. With `md_valid_e` high, the op completes in 1 cycle with `alu_result` = 0, `regwrite` passed through, and `pc_src_e` = 0.

## Test plan
- Forwarding: `forward_a_e`=10 with `alu_result_m`=0x10, `forward_b_e`=01 with `result_w`=0x5, ADD → `alu_result`=0x15 and `writedata`=0x5.
- Branch: BEQ with equal operands, `pc_e`=0x100, imm=0x20 → `pc_src_e`=1 and `pc_target_e`=0x120. With `md_valid_e`=1, `pc_src_e`=0.
- MUL 7 × −3 (XLEN=32) → `stall_e` high for 33 cycles, then `alu_result`=0xFFFFFFEB. MULHU 0xFFFFFFFF × 2 → 1.
- DIV 7/0 → 0xFFFFFFFF. REM 7/0 → 7. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- `flush_e` in the 10th BUSY cycle → FSM returns to IDLE, `stall_e` drops, and EX/MEM holds a bubble. `reset_n` pulsed low mid-op → all outputs are 0 immediately, asynchronously.
- `EX_MULDIV_EN` undefined, DIVU op → no stall, and `alu_result`=0 after 1 cycle.
